// File: rtl/mpc_pkg.sv
// Shared types and defaults for the output-port arbiter slice.
package mpc_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned PORTNUM_DEF  = 16;
  localparam int unsigned MAX_WAIT_DEF = 64;

endpackage

// File: rtl/mpc_rr_pick.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping from N-1 back to 0.
module mpc_rr_pick
  import mpc_pkg::*;
#(
  parameter  int unsigned N   = PORTNUM_DEF,
  localparam int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [N-1:0]   o_onehot,
  output logic [IDW-1:0] o_id,
  output logic           o_any
);

  localparam logic [IDW:0] NV = (IDW + 1)'(N);

  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_idx;

  // Walk the request vector starting at the pointer; the first hit wins.
  always_comb begin
    o_onehot = '0;
    o_id     = '0;
    o_any    = 1'b0;
    w_sum    = '0;
    w_idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_sum = {1'b0, i_ptr} + (IDW + 1)'(k);
      if (w_sum >= NV) begin
        w_sum = w_sum - NV;
      end
      w_idx = w_sum[IDW-1:0];
      if (!o_any && i_req[w_idx]) begin
        o_any           = 1'b1;
        o_onehot[w_idx] = 1'b1;
        o_id            = w_idx;
      end
    end
  end

endmodule

// File: rtl/oport_arbiter.sv
// Per-output-port arbiter: round-robin grant with one-cycle resp pulse, refusal
// (nresp) when the port is not ready or a waiter times out, ownership held
// until i_done.
module oport_arbiter
  import mpc_pkg::*;
#(
  parameter  int unsigned PORTNUM  = PORTNUM_DEF,
  parameter  int unsigned MAX_WAIT = MAX_WAIT_DEF,
  localparam int unsigned IDW      = $clog2(PORTNUM)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [PORTNUM-1:0] i_req,
  input  logic               i_port_ready,
  input  logic               i_done,
  output logic [PORTNUM-1:0] o_resp,
  output logic [PORTNUM-1:0] o_nresp,
  output logic [IDW-1:0]     o_grant_id,
  output logic               o_grant_vld
);

  arb_state_e         r_state;
  arb_state_e         w_state_nxt;

  logic [PORTNUM-1:0] r_resp;
  logic [PORTNUM-1:0] r_nresp;
  logic [IDW-1:0]     r_grant_id;
  logic               r_grant_vld;
  logic [IDW-1:0]     r_ptr;
  logic [PORTNUM-1:0] r_mask;

  logic [PORTNUM-1:0] w_owner_oh;
  logic [PORTNUM-1:0] w_elig;
  logic [PORTNUM-1:0] w_tmo;
  logic [PORTNUM-1:0] w_pick_oh;
  logic [IDW-1:0]     w_pick_id;
  logic               w_pick_any;

  logic [PORTNUM-1:0] w_resp_nxt;
  logic [PORTNUM-1:0] w_nresp_nxt;
  logic [IDW-1:0]     w_grant_id_nxt;
  logic [IDW-1:0]     w_ptr_nxt;

  // The owner's own request is excluded outright so it can never time out,
  // even if it drops and re-raises its request while still owning the port.
  assign w_owner_oh = r_grant_vld ? (PORTNUM'(1) << r_grant_id) : '0;
  assign w_elig     = i_req & ~r_mask & ~w_owner_oh;

  mpc_rr_pick #(
    .N (PORTNUM)
  ) u_pick (
    .i_req    (w_elig),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_oh),
    .o_id     (w_pick_id),
    .o_any    (w_pick_any)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: grant moves to BUSY, i_done releases back to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: if (w_pick_any && i_port_ready) w_state_nxt = ARB_BUSY;
      ARB_BUSY: if (i_done) w_state_nxt = ARB_IDLE;
      default:  w_state_nxt = ARB_IDLE;
    endcase
  end

  // Next values of the registered outputs and the round-robin pointer.
  always_comb begin
    w_resp_nxt     = '0;
    w_nresp_nxt    = w_tmo;
    w_grant_id_nxt = r_grant_id;
    w_ptr_nxt      = r_ptr;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_any) begin
          if (i_port_ready) begin
            w_resp_nxt     = w_pick_oh;
            w_grant_id_nxt = w_pick_id;
          end else begin
            w_nresp_nxt = w_elig;
          end
        end
      end
      ARB_BUSY: begin
        if (i_done) begin
          w_ptr_nxt = (r_grant_id == IDW'(PORTNUM - 1)) ? '0 : r_grant_id + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output, pointer and answered-mask registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_resp      <= '0;
      r_nresp     <= '0;
      r_grant_id  <= '0;
      r_grant_vld <= 1'b0;
      r_ptr       <= '0;
      r_mask      <= '0;
    end else begin
      r_resp      <= w_resp_nxt;
      r_nresp     <= w_nresp_nxt;
      r_grant_id  <= w_grant_id_nxt;
      r_grant_vld <= (w_state_nxt == ARB_BUSY);
      r_ptr       <= w_ptr_nxt;
      // A bit stays answered until its request is seen low; a new answer wins.
      r_mask      <= (r_mask & i_req) | w_resp_nxt | w_nresp_nxt;
    end
  end

  generate
    if (MAX_WAIT > 0) begin : g_tmo
      localparam int unsigned CW = $clog2(MAX_WAIT + 1);
      logic [CW-1:0] r_wcnt [PORTNUM];

      // Per-requester wait counters, running only while eligible during BUSY.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int unsigned i = 0; i < PORTNUM; i++) r_wcnt[i] <= '0;
        end else begin
          for (int unsigned i = 0; i < PORTNUM; i++) begin
            if (r_state == ARB_BUSY && w_elig[i]) begin
              if (r_wcnt[i] == CW'(MAX_WAIT)) r_wcnt[i] <= '0;
              else                            r_wcnt[i] <= r_wcnt[i] + 1'b1;
            end else begin
              r_wcnt[i] <= '0;
            end
          end
        end
      end

      // Timeout refusal once a waiter has been counted up to MAX_WAIT.
      always_comb begin
        w_tmo = '0;
        for (int unsigned i = 0; i < PORTNUM; i++) begin
          w_tmo[i] = (r_state == ARB_BUSY) && w_elig[i] && (r_wcnt[i] == CW'(MAX_WAIT));
        end
      end
    end else begin : g_no_tmo
      assign w_tmo = '0;
    end
  endgenerate

  assign o_resp      = r_resp;
  assign o_nresp     = r_nresp;
  assign o_grant_id  = r_grant_id;
  assign o_grant_vld = r_grant_vld;

endmodule
